my_inner_prod_pipe: RTL and testbench

Parametrised, fully pipelined signed inner-product engine: the successor to the fixed 4-element inner-product datapath behind `my_rt_sig_if`. Each accepted beat multiplies an N-element input vector by an N-element coefficient vector and sums the products in an adder tree. An optional frame-accumulate mode sums consecutive beats until `in_last`. It sits on the real-time path with valid/ready backpressure. Coefficients and mode come from the AXI4-Lite register block.

---
 rtl/my_inner_prod_pkg.sv | 19 +
 rtl/my_pipe_add_tree.sv | 47 ++++
 rtl/my_inner_prod_pipe.sv | 149 ++++++++++++++
 tb/tb_my_inner_prod_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_inner_prod_pkg.sv
// rtl/my_inner_prod_pkg.sv - shared widths and beat sideband for the inner-product pipe
package my_inner_prod_pkg;

    // Extra accumulator headroom above one full-precision beat sum
    localparam int ACC_GUARD_BITS = 16;

    // Full-precision width of one beat: product width plus adder-tree growth
    function automatic int sum_w(input int data_w, input int vec_len);
        return 2 * data_w + $clog2(vec_len);
    endfunction

    // Per-beat control that travels alongside the datapath
    typedef struct packed {
        logic valid;
        logic acc_en;
        logic last;
    } beat_side_t;

endpackage

// File: rtl/my_pipe_add_tree.sv
// rtl/my_pipe_add_tree.sv - registered pairwise signed adder tree with shared enable
module my_pipe_add_tree #(
    parameter int VEC_LEN = 4,
    parameter int IN_W    = 64
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               i_en,
    input  logic [VEC_LEN-1:0][IN_W-1:0]       i_data,
    output logic [IN_W+$clog2(VEC_LEN)-1:0]    o_sum
);

    localparam int LEVELS = $clog2(VEC_LEN);
    localparam int SUM_W  = IN_W + LEVELS;

    // Heap layout: node j sums children 2j and 2j+1; indices VEC_LEN.. are the
    // sign-extended leaves, 1..VEC_LEN-1 are registers, node 1 is the root.
    // The tree is complete, so every path has the same register depth.
    logic [SUM_W-1:0] r_node [1:VEC_LEN-1];
    logic [SUM_W-1:0] w_all  [1:2*VEC_LEN-1];

    // Gather leaves and registered nodes into one indexable view
    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            w_all[VEC_LEN+i] = {{LEVELS{i_data[i][IN_W-1]}}, i_data[i]};
        end
        for (int j = 1; j < VEC_LEN; j++) begin
            w_all[j] = r_node[j];
        end
    end

    // Every node registers the sum of its two children when the pipe advances
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int j = 1; j < VEC_LEN; j++) begin
                r_node[j] <= '0;
            end
        end else if (i_en) begin
            for (int j = 1; j < VEC_LEN; j++) begin
                r_node[j] <= w_all[2*j] + w_all[2*j+1];
            end
        end
    end

    assign o_sum = w_all[1];

endmodule

// File: rtl/my_inner_prod_pipe.sv
// rtl/my_inner_prod_pipe.sv - pipelined signed inner product with frame accumulate
module my_inner_prod_pipe
    import my_inner_prod_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 32
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              clr,
    input  logic                              acc_en,
    input  logic [VEC_LEN-1:0][DATA_W-1:0]    coef,
    input  logic [VEC_LEN-1:0][DATA_W-1:0]    in_vec,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [OUT_W-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int LEVELS = $clog2(VEC_LEN);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = sum_w(DATA_W, VEC_LEN);
    localparam int ACC_W  = SUM_W + ACC_GUARD_BITS;

    logic                             r_init;
    logic                             w_en;

    // Input register stage: operands are captured before the multiplier so the
    // multiply gets a full cycle of its own.
    logic [VEC_LEN-1:0][DATA_W-1:0]   r_s_vec;
    logic [VEC_LEN-1:0][DATA_W-1:0]   r_s_coef;
    beat_side_t                       r_s_side;

    logic [VEC_LEN-1:0][PROD_W-1:0]   w_prod;
    logic [VEC_LEN-1:0][PROD_W-1:0]   r_p_prod;
    beat_side_t                       r_p_side;

    beat_side_t                       r_t_side [LEVELS];
    logic [SUM_W-1:0]                 w_tree_sum;

    beat_side_t                       w_a_side;
    logic                             w_a_last;
    logic [ACC_W-1:0]                 r_acc;
    logic [ACC_W-1:0]                 w_acc_next;
    logic [OUT_W-1:0]                 r_out_data;
    logic                             r_out_valid;

    // Global stall: the whole pipe moves only when the output slot is free
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = r_init && w_en && !clr;

    assign w_a_side   = r_t_side[LEVELS-1];
    assign w_a_last   = !w_a_side.acc_en || w_a_side.last;
    assign w_acc_next = r_acc + {{ACC_GUARD_BITS{w_tree_sum[SUM_W-1]}}, w_tree_sum};

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // Hold in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    // Full-precision signed products of the registered operands
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            w_prod[i] = PROD_W'($signed(r_s_vec[i])) * PROD_W'($signed(r_s_coef[i]));
        end
    end

    // Operand and product registers; data needs no flush, only valid bits do
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s_vec  <= '0;
            r_s_coef <= '0;
            r_p_prod <= '0;
        end else if (w_en) begin
            r_s_vec  <= in_vec;
            r_s_coef <= coef;
            r_p_prod <= w_prod;
        end
    end

    // Sideband pipe tracking valid/acc_en/last in step with the datapath
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s_side <= '0;
            r_p_side <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                r_t_side[l] <= '0;
            end
        end else if (clr) begin
            r_s_side <= '0;
            r_p_side <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                r_t_side[l] <= '0;
            end
        end else if (w_en) begin
            r_s_side    <= '{valid: in_valid && in_ready, acc_en: acc_en, last: in_last};
            r_p_side    <= r_s_side;
            r_t_side[0] <= r_p_side;
            for (int l = 1; l < LEVELS; l++) begin
                r_t_side[l] <= r_t_side[l-1];
            end
        end
    end

    my_pipe_add_tree #(
        .VEC_LEN (VEC_LEN),
        .IN_W    (PROD_W)
    ) u_add_tree (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_en    (w_en),
        .i_data  (r_p_prod),
        .o_sum   (w_tree_sum)
    );

    // Accumulate beat sums; a closing beat emits acc+sum and restarts the frame
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_a_side.valid && w_a_last;
            if (w_a_side.valid) begin
                if (w_a_last) begin
                    r_out_data <= w_acc_next[OUT_W-1:0];
                    r_acc      <= '0;
                end else begin
                    r_acc      <= w_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_inner_prod_pipe.sv
// tb/tb_my_inner_prod_pipe.sv - scoreboard bench for my_inner_prod_pipe
module tb_my_inner_prod_pipe;

    localparam int VL = 4;
    localparam int DW = 32;
    localparam int OW = 32;

    logic               clk = 1'b0;
    logic               arst_n = 1'b1;
    logic               clr = 1'b0;
    logic               acc_en = 1'b0;
    logic [VL-1:0][DW-1:0] coef = '0;
    logic [VL-1:0][DW-1:0] in_vec = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic [OW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;

    int                 n_checks = 0;
    int                 n_pass = 0;
    logic [31:0]        exp_q[$];
    logic [63:0]        model_acc = '0;
    logic [31:0]        mon_exp;

    my_inner_prod_pipe #(.VEC_LEN(VL), .DATA_W(DW), .OUT_W(OW)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .clr       (clr),
        .acc_en    (acc_en),
        .coef      (coef),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [VL-1:0][DW-1:0] v4(input int a, input int b, input int c, input int d);
        logic [VL-1:0][DW-1:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic logic [63:0] dot(input logic [VL-1:0][DW-1:0] v, input logic [VL-1:0][DW-1:0] c);
        longint s;
        longint a;
        longint b;
        s = 0;
        for (int i = 0; i < VL; i++) begin
            a = longint'($signed(v[i]));
            b = longint'($signed(c[i]));
            s += a * b;
        end
        return s;
    endfunction

    // Scoreboard: every handshaken output must match the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output got %h required none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) $display("FAIL out_data got %h required %h", out_data, mon_exp);
                else n_pass++;
            end
        end
    end

    task automatic send(input logic [VL-1:0][DW-1:0] v, input logic [VL-1:0][DW-1:0] c,
                        input logic ae, input logic last, output int waits);
        logic ok;
        logic [63:0] d;
        in_vec = v; coef = c; acc_en = ae; in_last = last; in_valid = 1'b1;
        waits = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
            waits++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL accept_timeout got in_ready=%b required 1", in_ready);
        end else begin
            n_pass++;
            d = dot(v, c);
            if (!ae || last) begin
                exp_q.push_back(32'(model_acc + d));
                model_acc = '0;
            end else begin
                model_acc = model_acc + d;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
        else n_pass++;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        #2 arst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h required 0", out_data); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready); else n_pass++;
        arst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL release_in_ready got %b required 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL first_edge_in_ready got %b required 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int w;
        int lat;
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b0, 1'b0, w);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b required 0", out_valid); else n_pass++;
        wait_out(lat);
        n_checks++; if (lat != 4) $display("FAIL basic_latency got %0d required 4", lat); else n_pass++;
        n_checks++; if (out_data !== 32'd70) $display("FAIL basic_data got %0d required 70", out_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b required 0", out_valid); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int w1;
        int w2;
        int lat;
        send(v4(1, 1, 1, 1), v4(1, 2, 3, 4), 1'b0, 1'b0, w1);
        send(v4(-1, -1, -1, -1), v4(1, 2, 3, 4), 1'b0, 1'b0, w2);
        n_checks++; if (w2 != 0) $display("FAIL b2b_in_ready got %0d waits required 0", w2); else n_pass++;
        wait_out(lat);
        n_checks++; if (out_data !== 32'd10) $display("FAIL b2b_first got %0d required 10", out_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== -32'sd10)
            $display("FAIL b2b_second got valid=%b data=%h required 1/%h", out_valid, out_data, -32'sd10);
        else n_pass++;
        drain();
    endtask

    task automatic test_accum();
        int w;
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b1, 1'b1, w);
        n_checks++; if (exp_q.size() != 1 || exp_q[0] !== 32'd210) $display("FAIL accum_model got %0d entries required 1 of 210", exp_q.size()); else n_pass++;
        drain();
        send(v4(3, 0, 0, 0), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        send(v4(0, -2, 0, 0), v4(1, 2, 3, 4), 1'b0, 1'b0, w);
        send(v4(0, 0, 0, 1), v4(9, 9, 9, 9), 1'b0, 1'b0, w);
        drain();
    endtask

    task automatic test_stall();
        int w;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(v4(i, i, i, i), v4(1, 2, 3, 4), 1'b0, 1'b0, w);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b required 0", in_ready); else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd10)
                $display("FAIL stall_hold got valid=%b data=%0d required 1/10", out_valid, out_data);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_overflow();
        int w;
        int lat;
        send(v4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
             v4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 1'b0, 1'b0, w);
        wait_out(lat);
        n_checks++; if (out_data !== 32'h4) $display("FAIL overflow_max got %h required 00000004", out_data); else n_pass++;
        drain();
        send(v4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
             v4(32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF), 1'b0, 1'b0, w);
        drain();
    endtask

    task automatic test_clr();
        int w;
        send(v4(1, 1, 1, 1), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        send(v4(2, 2, 2, 2), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        repeat (6) @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL clr_in_ready got %b required 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        clr = 1'b0;
        model_acc = '0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL clr_out_valid got %b required 0", out_valid); else n_pass++;
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b1, 1'b1, w);
        drain();
        send(v4(4, 4, 4, 4), v4(1, 2, 3, 4), 1'b0, 1'b0, w);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_q.delete();
        model_acc = '0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_arst();
        int w;
        send(v4(1, 1, 1, 1), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        send(v4(2, 2, 2, 2), v4(1, 2, 3, 4), 1'b1, 1'b0, w);
        repeat (6) @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %b required 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL arst_in_ready got %b required 0", in_ready); else n_pass++;
        @(negedge clk);
        arst_n = 1'b1;
        exp_q.delete();
        model_acc = '0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL arst_release_ready got %b required 1", in_ready); else n_pass++;
        send(v4(5, 6, 7, 8), v4(1, 2, 3, 4), 1'b1, 1'b1, w);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_accum();
        test_stall();
        test_overflow();
        test_clr();
        test_arst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule
